ascon_fsm: RTL



---
 rtl/ascon_pack.sv | 52 +++++
 rtl/ascon_round_counter.sv | 51 +++++
 rtl/ascon_fsm.sv | 248 ++++++++++++++++++++++++
 3 files changed

// File: rtl/ascon_pack.sv
// ascon_pack: shared constants and types for the ASCON-128 sequencing controller.
//   - xor_up / xor_down mode encodings driven to the permutation datapath
//   - permutation round counts (p12 / p6) and derived round indices
//   - controller state enum and the bundle of per-cycle control outputs
package ascon_pack;

    // xor_up modes (S0 ^= data, S1S2 ^= K)
    localparam logic [1:0] UP_NONE     = 2'd0;
    localparam logic [1:0] UP_DATA     = 2'd1;
    localparam logic [1:0] UP_KEY      = 2'd2;
    localparam logic [1:0] UP_DATA_KEY = 2'd3;

    // xor_down modes (S3S4 ^= K, S4 ^= 1)
    localparam logic [1:0] DOWN_NONE     = 2'd0;
    localparam logic [1:0] DOWN_KEY      = 2'd1;
    localparam logic [1:0] DOWN_DSEP     = 2'd2;
    localparam logic [1:0] DOWN_KEY_DSEP = 2'd3;

    localparam logic [3:0] ROUNDS_A = 4'd12;
    localparam logic [3:0] ROUNDS_B = 4'd6;

    // p6 runs the last six round constants of p12, so it starts at 12-6
    localparam logic [3:0] ROUND_FIRST_A = 4'd0;
    localparam logic [3:0] ROUND_FIRST_B = ROUNDS_A - ROUNDS_B;
    localparam logic [3:0] ROUND_LAST    = ROUNDS_A - 4'd1;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_INIT    = 3'd1,
        ST_WAIT_AD = 3'd2,
        ST_AD      = 3'd3,
        ST_WAIT_PT = 3'd4,
        ST_PT      = 3'd5,
        ST_FINAL   = 3'd6,
        ST_DONE    = 3'd7
    } state_t;

    typedef struct packed {
        logic       select;
        logic       enable_state;
        logic [1:0] etat_up;
        logic [1:0] etat_down;
        logic       enable_cipher;
        logic       enable_tag;
        logic       data_ready;
        logic       busy;
        logic       done;
    } ctrl_t;

    localparam ctrl_t CTRL_NONE = ctrl_t'(11'd0);

endpackage

// File: rtl/ascon_round_counter.sv
// ascon_round_counter: 4-bit permutation round index.
//   clock_i      : system clock
//   reset_i      : synchronous active-high reset (count -> 0)
//   load_i       : load load_value_i (0 for p12, 6 for p6); has priority
//   load_value_i : value to load
//   enable_i     : advance by one round
//   count_o      : registered round index
//   count_next_o : value the index takes at the next edge
//   last_o       : registered index is the final round (11)
module ascon_round_counter
    import ascon_pack::*;
(
    input  logic       clock_i,
    input  logic       reset_i,
    input  logic       load_i,
    input  logic [3:0] load_value_i,
    input  logic       enable_i,
    output logic [3:0] count_o,
    output logic [3:0] count_next_o,
    output logic       last_o
);

    logic [3:0] count_r;
    logic [3:0] count_next_s;

    // next round index: load wins over increment, otherwise hold
    always_comb begin
        count_next_s = count_r;
        if (load_i) begin
            count_next_s = load_value_i;
        end else if (enable_i) begin
            count_next_s = count_r + 4'd1;
        end else begin
            count_next_s = count_r;
        end
    end

    // round index register
    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            count_r <= 4'd0;
        end else begin
            count_r <= count_next_s;
        end
    end

    assign count_o      = count_r;
    assign count_next_o = count_next_s;
    assign last_o       = (count_r == ROUND_LAST);

endmodule

// File: rtl/ascon_fsm.sv
// ascon_fsm: sequencing controller for the ASCON-128 permutation datapath.
// Runs p12 init, p6 per AD block, p6 per plaintext block (last block goes
// into the p12 finalization) and pulses done_o once the tag is captured.
//   clock_i / reset_i       : clock, synchronous active-high reset
//   start_i                 : begin one encryption (only looked at in IDLE)
//   data_i / data_valid_i   : upstream 64-bit block and its valid
//   data_ready_o            : controller is waiting for a block
//   data_o                  : last accepted block (datapath xor_data_i)
//   select_o, round_o, enable_state_o, etat_up_o, etat_down_o,
//   enable_cipher_o, enable_tag_o : datapath control
//   cipher_valid_o          : enable_cipher_o delayed one cycle
//   busy_o / done_o         : not idle / tag valid pulse
// Control outputs are registered: they are decoded from the next state
// and next round index so that they line up with the state they describe.
module ascon_fsm
    import ascon_pack::*;
#(
    parameter int NB_AD = 1,
    parameter int NB_PT = 4
) (
    input  logic        clock_i,
    input  logic        reset_i,
    input  logic        start_i,
    input  logic [63:0] data_i,
    input  logic        data_valid_i,
    output logic        data_ready_o,
    output logic [63:0] data_o,
    output logic        select_o,
    output logic [3:0]  round_o,
    output logic        enable_state_o,
    output logic [1:0]  etat_up_o,
    output logic [1:0]  etat_down_o,
    output logic        enable_cipher_o,
    output logic        enable_tag_o,
    output logic        cipher_valid_o,
    output logic        busy_o,
    output logic        done_o
);

    // with NB_AD = 0 LAST_AD is 255 and is never reached
    localparam logic [7:0] LAST_AD = 8'(NB_AD - 1);
    localparam logic [7:0] LAST_PT = 8'(NB_PT - 1);
    localparam logic       HAS_AD  = (NB_AD > 0) ? 1'b1 : 1'b0;

    state_t      state_r;
    state_t      state_next_s;
    logic [7:0]  ad_cnt_r;
    logic [7:0]  ad_cnt_next_s;
    logic [7:0]  pt_cnt_r;
    logic [7:0]  pt_cnt_next_s;
    logic [63:0] data_r;
    logic [63:0] data_next_s;
    ctrl_t       ctrl_r;
    logic        cipher_valid_r;

    logic        cnt_load_s;
    logic [3:0]  cnt_value_s;
    logic        cnt_enable_s;
    logic [3:0]  round_s;
    logic [3:0]  round_next_s;
    logic        round_last_s;

    ascon_round_counter u_round_counter (
        .clock_i      (clock_i),
        .reset_i      (reset_i),
        .load_i       (cnt_load_s),
        .load_value_i (cnt_value_s),
        .enable_i     (cnt_enable_s),
        .count_o      (round_s),
        .count_next_o (round_next_s),
        .last_o       (round_last_s)
    );

    // control word for a given state/round; last_ad marks the final AD block
    function automatic ctrl_t decode_ctrl(input state_t st, input logic [3:0] rnd,
                                          input logic last_ad);
        ctrl_t c;
        c = CTRL_NONE;
        case (st)
            ST_IDLE: begin
                c = CTRL_NONE;
            end
            ST_INIT: begin
                c.busy         = 1'b1;
                c.enable_state = 1'b1;
                c.select       = (rnd == ROUND_FIRST_A);
                if (rnd == ROUND_LAST) begin
                    c.etat_down = HAS_AD ? DOWN_KEY : DOWN_KEY_DSEP;
                end else begin
                    c.etat_down = DOWN_NONE;
                end
            end
            ST_WAIT_AD, ST_WAIT_PT: begin
                c.busy       = 1'b1;
                c.data_ready = 1'b1;
            end
            ST_AD: begin
                c.busy         = 1'b1;
                c.enable_state = 1'b1;
                c.etat_up      = (rnd == ROUND_FIRST_B) ? UP_DATA : UP_NONE;
                c.etat_down    = ((rnd == ROUND_LAST) && last_ad) ? DOWN_DSEP : DOWN_NONE;
            end
            ST_PT: begin
                c.busy          = 1'b1;
                c.enable_state  = 1'b1;
                c.etat_up       = (rnd == ROUND_FIRST_B) ? UP_DATA : UP_NONE;
                c.enable_cipher = (rnd == ROUND_FIRST_B);
            end
            ST_FINAL: begin
                c.busy          = 1'b1;
                c.enable_state  = 1'b1;
                c.etat_up       = (rnd == ROUND_FIRST_A) ? UP_DATA_KEY : UP_NONE;
                c.enable_cipher = (rnd == ROUND_FIRST_A);
                c.etat_down     = (rnd == ROUND_LAST) ? DOWN_KEY : DOWN_NONE;
                c.enable_tag    = (rnd == ROUND_LAST);
            end
            ST_DONE: begin
                c.busy = 1'b1;
                c.done = 1'b1;
            end
            default: begin
                c = CTRL_NONE;
            end
        endcase
        return c;
    endfunction

    // next-state, counters, block latch and round counter commands
    always_comb begin
        state_next_s  = state_r;
        ad_cnt_next_s = ad_cnt_r;
        pt_cnt_next_s = pt_cnt_r;
        data_next_s   = data_r;
        cnt_load_s    = 1'b0;
        cnt_value_s   = ROUND_FIRST_A;
        cnt_enable_s  = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (start_i) begin
                    state_next_s  = ST_INIT;
                    ad_cnt_next_s = 8'd0;
                    pt_cnt_next_s = 8'd0;
                    cnt_load_s    = 1'b1;
                    cnt_value_s   = ROUND_FIRST_A;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_INIT: begin
                if (round_last_s) begin
                    state_next_s = HAS_AD ? ST_WAIT_AD : ST_WAIT_PT;
                end else begin
                    cnt_enable_s = 1'b1;
                end
            end
            ST_WAIT_AD: begin
                if (data_valid_i) begin
                    data_next_s  = data_i;
                    state_next_s = ST_AD;
                    cnt_load_s   = 1'b1;
                    cnt_value_s  = ROUND_FIRST_B;
                end else begin
                    state_next_s = ST_WAIT_AD;
                end
            end
            ST_AD: begin
                if (round_last_s) begin
                    ad_cnt_next_s = ad_cnt_r + 8'd1;
                    state_next_s  = (ad_cnt_r == LAST_AD) ? ST_WAIT_PT : ST_WAIT_AD;
                end else begin
                    cnt_enable_s = 1'b1;
                end
            end
            ST_WAIT_PT: begin
                if (data_valid_i) begin
                    data_next_s = data_i;
                    cnt_load_s  = 1'b1;
                    // the last plaintext block is absorbed by the finalization
                    if (pt_cnt_r == LAST_PT) begin
                        state_next_s = ST_FINAL;
                        cnt_value_s  = ROUND_FIRST_A;
                    end else begin
                        state_next_s = ST_PT;
                        cnt_value_s  = ROUND_FIRST_B;
                    end
                end else begin
                    state_next_s = ST_WAIT_PT;
                end
            end
            ST_PT: begin
                if (round_last_s) begin
                    pt_cnt_next_s = pt_cnt_r + 8'd1;
                    state_next_s  = ST_WAIT_PT;
                end else begin
                    cnt_enable_s = 1'b1;
                end
            end
            ST_FINAL: begin
                if (round_last_s) begin
                    state_next_s = ST_DONE;
                end else begin
                    cnt_enable_s = 1'b1;
                end
            end
            ST_DONE: begin
                state_next_s = ST_IDLE;
                cnt_load_s   = 1'b1;
                cnt_value_s  = ROUND_FIRST_A;
            end
            default: begin
                state_next_s = ST_IDLE;
            end
        endcase
    end

    // state, counters, data block and registered control outputs
    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            state_r        <= ST_IDLE;
            ad_cnt_r       <= 8'd0;
            pt_cnt_r       <= 8'd0;
            data_r         <= 64'd0;
            ctrl_r         <= CTRL_NONE;
            cipher_valid_r <= 1'b0;
        end else begin
            state_r        <= state_next_s;
            ad_cnt_r       <= ad_cnt_next_s;
            pt_cnt_r       <= pt_cnt_next_s;
            data_r         <= data_next_s;
            ctrl_r         <= decode_ctrl(state_next_s, round_next_s, (ad_cnt_next_s == LAST_AD));
            cipher_valid_r <= ctrl_r.enable_cipher;
        end
    end

    assign data_ready_o    = ctrl_r.data_ready;
    assign data_o          = data_r;
    assign select_o        = ctrl_r.select;
    assign round_o         = round_s;
    assign enable_state_o  = ctrl_r.enable_state;
    assign etat_up_o       = ctrl_r.etat_up;
    assign etat_down_o     = ctrl_r.etat_down;
    assign enable_cipher_o = ctrl_r.enable_cipher;
    assign enable_tag_o    = ctrl_r.enable_tag;
    assign cipher_valid_o  = cipher_valid_r;
    assign busy_o          = ctrl_r.busy;
    assign done_o          = ctrl_r.done;

endmodule
